// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums NUM_TERMS unsigned products per result and
// hands each result downstream over valid/ready with a sticky wrap flag.
module product_accumulator #(
    parameter int PROD_W    = 8,
    parameter int NUM_TERMS = 4,
    parameter int CNT_W     = 2,
    parameter int ACC_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod_data,
    output logic              prod_ready,
    output logic              acc_valid,
    output logic [ACC_W-1:0]  acc_data,
    output logic              acc_ovf,
    input  logic              acc_ready,
    output logic [CNT_W-1:0]  term_cnt
);

    typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               res_ovf_q, res_ovf_d;

    logic [PROD_W-1:0]  prod_m;
    logic [ACC_W:0]     sum;
    logic               accept;
    logic               last;

    // Mask the operand so an undriven product bus never reaches the adder.
    assign prod_m = prod_valid ? prod_data : '0;
    assign sum    = {1'b0, acc_q} + (ACC_W+1)'(prod_m);
    assign accept = prod_valid & prod_ready;
    assign last   = (cnt_q == CNT_W'(NUM_TERMS - 1));

    assign prod_ready = (state_q == ST_ACC);
    assign acc_valid  = (state_q == ST_OUT);
    assign acc_data   = res_q;
    assign acc_ovf    = res_ovf_q;
    assign term_cnt   = cnt_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        if (clear) begin
            // Abort wins over any beat or handoff; the last result value stays visible.
            state_d = ST_ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        if (last) begin
                            res_d     = sum[ACC_W-1:0];
                            res_ovf_d = ovf_q | sum[ACC_W];
                            acc_d     = '0;
                            ovf_d     = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_OUT;
                        end else begin
                            acc_d = sum[ACC_W-1:0];
                            ovf_d = ovf_q | sum[ACC_W];
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (acc_ready) state_d = ST_ACC;
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

endmodule
